// File: rtl/token_extractor.sv
// Byte-stream tokenizer: splits ASCII input into words and reports BEGIN / END /
// OTHER keyword tokens plus an end-of-stream marker, with a counted word total.
module token_extractor (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        tok_valid,
  output logic [1:0]  tok_code,
  output logic        tok_last,
  input  logic        tok_ready,
  output logic [15:0] word_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  localparam logic [1:0]  CODE_OTHER = 2'b00;
  localparam logic [1:0]  CODE_BEGIN = 2'b01;
  localparam logic [1:0]  CODE_END   = 2'b10;
  localparam logic [1:0]  CODE_EOS   = 2'b11;
  localparam logic [39:0] KW_BEGIN   = 40'h62_65_67_69_6e;  // "begin"
  localparam logic [39:0] KW_END     = 40'h00_00_65_6e_64;  // "end"

  state_t      r_state, w_state_nxt;
  logic [39:0] r_buf, w_buf_nxt, w_inc_buf;
  logic [2:0]  r_len, w_len_nxt, w_inc_len;
  logic        r_tok_valid;
  logic [1:0]  r_tok_code;
  logic        r_tok_last;
  logic [15:0] r_word_cnt;

  logic        w_accept, w_is_delim, w_word_open, w_open_after, w_emit;
  logic [7:0]  w_folded;
  logic [1:0]  w_emit_code;

  assign in_ready  = !r_tok_valid || tok_ready;
  assign tok_valid = r_tok_valid;
  assign tok_code  = r_tok_code;
  assign tok_last  = r_tok_last;
  assign word_cnt  = r_word_cnt;

  assign w_accept     = in_valid && in_ready;
  assign w_is_delim   = in_data inside {8'h20, 8'h09, 8'h0A, 8'h0D};
  assign w_folded     = (in_data >= 8'h41 && in_data <= 8'h5A) ? (in_data | 8'h20) : in_data;
  assign w_word_open  = (r_state != ST_IDLE);
  assign w_open_after = w_word_open || !w_is_delim;
  // A token is produced by a delimiter closing a word, or by any last byte.
  assign w_emit       = w_accept && ((w_word_open && w_is_delim) || in_last);

  // Word contents as they would be with this byte appended (delimiters leave it as is).
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_inc_buf = r_buf;
    w_inc_len = r_len;
    if (!w_is_delim) begin
      if (r_len < 3'd5) w_inc_buf = {r_buf[31:0], w_folded};
      if (r_len != 3'd6) w_inc_len = r_len + 3'd1;
    end
  end

  always_comb begin
    w_emit_code = CODE_OTHER;
    if (!w_open_after)                                   w_emit_code = CODE_EOS;
    else if (w_inc_len == 3'd5 && w_inc_buf == KW_BEGIN) w_emit_code = CODE_BEGIN;
    else if (w_inc_len == 3'd3 && w_inc_buf == KW_END)   w_emit_code = CODE_END;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_len_nxt   = r_len;
    if (w_accept) begin
      if (w_emit) begin
        w_state_nxt = ST_IDLE;
        w_buf_nxt   = '0;
        w_len_nxt   = '0;
      end else if (!w_is_delim) begin
        w_state_nxt = (w_inc_len == 3'd6) ? ST_LONG : ST_WORD;
        w_buf_nxt   = w_inc_buf;
        w_len_nxt   = w_inc_len;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_buf   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tok_valid <= 1'b0;
      r_tok_code  <= CODE_OTHER;
      r_tok_last  <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      if (w_emit) begin
        r_tok_valid <= 1'b1;
        r_tok_code  <= w_emit_code;
        r_tok_last  <= in_last;
      end else if (tok_ready) begin
        r_tok_valid <= 1'b0;
      end
      if (r_tok_valid && tok_ready && r_tok_code != CODE_EOS)
        r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_token_extractor.sv
// Directed bench for token_extractor: keyword detection, long words, stream end,
// backpressure, back-to-back tokens and mid-stream reset.
module tb_token_extractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        tok_valid;
  logic [1:0]  tok_code;
  logic        tok_last;
  logic        tok_ready;
  logic [15:0] word_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] C_OTHER = 2'b00;
  localparam logic [1:0] C_BEGIN = 2'b01;
  localparam logic [1:0] C_END   = 2'b10;
  localparam logic [1:0] C_EOS   = 2'b11;

  token_extractor dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .tok_valid (tok_valid),
    .tok_code  (tok_code),
    .tok_last  (tok_last),
    .tok_ready (tok_ready),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns #1 after the edge that accepted the byte, so token outputs are settled.
  task automatic send(input logic [7:0] b, input logic l);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = b; in_last = l;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_on_final);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; tok_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_tok(input string name, input logic [1:0] code, input logic last);
    n_tests++;
    if (tok_valid !== 1'b1 || tok_code !== code || tok_last !== last) begin
      n_fail++;
      $display("FAIL %s: got v=%b c=%b l=%b, want v=1 c=%b l=%b",
               name, tok_valid, tok_code, tok_last, code, last);
    end
  endtask

  task automatic expect_none(input string name);
    n_tests++;
    if (tok_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got tok_valid=%b, want 0", name, tok_valid);
    end
  endtask

  task automatic expect_cnt(input string name, input logic [15:0] cnt);
    n_tests++;
    if (word_cnt !== cnt) begin
      n_fail++;
      $display("FAIL %s: got word_cnt=%0d, want %0d", name, word_cnt, cnt);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tok_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    reset = 1'b1;
    #1;
    n_tests++;
    if (tok_valid !== 1'b0 || tok_code !== 2'b00 || tok_last !== 1'b0 ||
        word_cnt !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b c=%b l=%b cnt=%0d rdy=%b, want v=0 c=00 l=0 cnt=0 rdy=1",
               tok_valid, tok_code, tok_last, word_cnt, in_ready);
    end
    @(negedge clk);
    reset = 1'b0; tok_ready = 1'b1;
  endtask

  task automatic test_keywords();
    do_reset();
    send_str("begin", 1'b0);
    expect_none("kw_no_tok_midword");
    send(8'h20, 1'b0);
    expect_tok("kw_begin", C_BEGIN, 1'b0);
    send_str("end", 1'b0);
    expect_none("kw_begin_consumed");
    send(8'h20, 1'b0);
    expect_tok("kw_end", C_END, 1'b0);
    @(posedge clk); #1;
    expect_none("kw_end_consumed");
    expect_cnt("kw_word_cnt", 16'd2);
  endtask

  task automatic test_case_and_long();
    send_str("BeGiN ", 1'b0);
    expect_tok("mixed_case_begin", C_BEGIN, 1'b0);
    send_str("x ", 1'b0);
    expect_tok("short_other", C_OTHER, 1'b0);
    send_str("beginning", 1'b1);
    expect_tok("long_last_other", C_OTHER, 1'b1);
    @(posedge clk); #1;
    expect_cnt("long_word_cnt", 16'd5);
  endtask

  task automatic test_eos();
    send(8'h20, 1'b1);
    expect_tok("eos_token", C_EOS, 1'b1);
    @(posedge clk); #1;
    expect_cnt("eos_cnt_unchanged", 16'd5);
  endtask

  task automatic test_leading_delims();
    do_reset();
    send(8'h20, 1'b0);
    expect_none("lead_space1");
    send(8'h09, 1'b0);
    expect_none("lead_tab");
    send_str("end", 1'b1);
    expect_tok("lead_end_last", C_END, 1'b1);
    send_str("en\n\r", 1'b0);
    n_tests++;
    if (tok_valid !== 1'b0 || word_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL double_delim: got v=%b cnt=%0d, want v=0 cnt=2", tok_valid, word_cnt);
    end
  endtask

  task automatic test_idle_ignore();
    do_reset();
    send_str("en", 1'b0);
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h20; in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_last = 1'b0;
    expect_none("ignored_no_tok");
    send_str("d ", 1'b0);
    expect_tok("ignored_end", C_END, 1'b0);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    send_str("begin", 1'b0);
    tok_ready = 1'b0;
    send(8'h20, 1'b0);
    expect_tok("bp_token", C_BEGIN, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = "e"; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (in_ready !== 1'b0 || tok_valid !== 1'b1 || tok_code !== C_BEGIN) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d stalled cycles wrong (rdy=%b v=%b c=%b), want rdy=0 v=1 c=01",
               bad, in_ready, tok_valid, tok_code);
    end
    tok_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_cnt("bp_consumed_cnt", 16'd1);
    send_str("nd ", 1'b0);
    expect_tok("bp_no_loss_end", C_END, 1'b0);
    @(posedge clk); #1;
    expect_cnt("bp_final_cnt", 16'd2);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_str("a ", 1'b0);
    expect_tok("b2b_first", C_OTHER, 1'b0);
    send(8'h62, 1'b1);
    expect_tok("b2b_second", C_OTHER, 1'b1);
    @(posedge clk); #1;
    expect_none("b2b_drained");
    expect_cnt("b2b_cnt", 16'd2);
  endtask

  task automatic test_midstream_reset();
    do_reset();
    send_str("beg", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    expect_none("rst_no_stale_tok");
    send_str("end", 1'b0);
    expect_none("rst_no_tok_midword");
    send(8'h20, 1'b0);
    expect_tok("rst_end_only", C_END, 1'b0);
    @(posedge clk); #1;
    expect_cnt("rst_cnt", 16'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; tok_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_keywords();
    test_case_and_long();
    test_eos();
    test_leading_delims();
    test_idle_ignore();
    test_backpressure();
    test_back_to_back();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
